rram_op_sequencer: RTL and testbench
====================================

Name: rram_op_sequencer

Overview:
Command-level controller that sequences the RRAM array-access state counter. It accepts one operation at a time: cache-to-RRAM write, RRAM-to-cache read, or forming. It drives the matching strobe (we / re / forming) and the counter enable, then waits for the counter's completion flag. A per-operation watchdog, a response code and a completed-operation counter sit between the top-level command interface and the array datapath.

Parameters:
WRITE_TO, 40, max cycles in WRITE before timeout (counter needs 32 + margin)
READ_TO, 40, max cycles in READ before timeout
FORM_TO, 4200, max cycles in FORM before timeout (counter needs 4096 + margin)
TO_W, 13, watchdog counter width; must hold max(*_TO)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_op  in  2  00 WRITE, 01 READ, 10 FORM, 11 reserved
cmd_ready  out  1  sequencer can accept a command
err_clr  in  1  clears ERR state and sticky error
write_count_flag  in  1  write-count-complete flag from state counter
cache_count_flag  in  1  read-count-complete flag from state counter
forming_count_flag  in  1  forming-count-complete flag from state counter
en  out  1  state-counter enable
we  out  1  cache-to-RRAM write strobe
re  out  1  RRAM-to-cache read strobe
forming  out  1  forming strobe
done  out  1  one-cycle completion pulse
rsp_code  out  2  valid with done: 00 OK, 10 illegal op; 01 timeout (sticky)
err  out  1  sticky timeout indicator
op_count  out  16  completed-OK operation counter

Behaviour:
- All outputs are registered. Reset values: state IDLE; cmd_ready, en, we, re, forming, done, err = 0; rsp_code = 00; op_count = 0; watchdog = 0.
- States: IDLE, WRITE, READ, FORM, DONE, ERR.
- After reset release:
  - en = 1 on the first posedge and stays 1 in every state except ERR.
  - cmd_ready = 1 on the same posedge; cmd_ready = 1 only while in IDLE.
- Accept: cmd_valid & cmd_ready at posedge.
  - op 00/01/10: go to WRITE/READ/FORM. The matching strobe rises on the same edge, so latency is 1 cycle from accept. cmd_ready drops on that edge.
  - op 11: go to DONE with rsp_code = 10; no strobe asserted; op_count unchanged.
- Exactly one strobe may be high at any time; all strobes are low outside WRITE/READ/FORM.
- In an op state, the watchdog increments each cycle starting from 0 at entry.
  - Matching flag sampled high: go to DONE. Strobe drops on that edge; done = 1 for one cycle with rsp_code = 00; op_count += 1, wrapping 0xFFFF -> 0.
  - Watchdog == *_TO - 1 with flag low: go to ERR. Strobe drops; done pulses with rsp_code = 01; err = 1 (sticky).
  - Flag and timeout in the same cycle: flag wins, response is OK.
  - Non-matching flags are ignored.
- DONE lasts exactly 1 cycle, then IDLE.
  - cmd_ready re-asserts one cycle after the strobe drops. This guarantees the strobe is low for at least one negedge, so the state counter clears between back-to-back operations.
- ERR: en = 0 (holds the state counter cleared), cmd_ready = 0, commands ignored.
  - err_clr sampled high: go to IDLE; err clears on the same edge; en = 1 and cmd_ready = 1 on that edge.
  - err_clr outside ERR has no effect.
- cmd_op is sampled only at accept; changes to it mid-operation are ignored.
- Reset asserted mid-operation: strobes, en, done and err drop asynchronously, state returns to IDLE, and op_count clears.

Test Plan:
1. Reset, then WRITE: hold cmd_valid with op 00; emulate write_count_flag high 32 cycles after we rises -> we high 33 cycles, done pulse with rsp_code 00, op_count = 1, cmd_ready high 2 cycles after the flag.
2. READ then FORM back-to-back, with cmd_valid held high and each flag returned on time -> re and forming never overlap, at least 1 low cycle between strobes, op_count = 2.
3. WRITE with write_count_flag never asserted -> we drops after 40 cycles, done with rsp_code 01, err = 1, en = 0; a new cmd_valid is ignored; err_clr -> err = 0, en = 1, cmd_ready = 1.
4. cmd_op = 11 -> no strobe, done 1 cycle after accept with rsp_code 10, op_count unchanged.
5. FORM, then assert rst at cycle 100 -> forming low immediately, state IDLE, op_count = 0; after release the next command completes normally.
6. READ with cache_count_flag asserted exactly on watchdog cycle 39 -> rsp_code 00, err stays 0.

Source files
------------

// File: rtl/rram_op_sequencer.sv
// Command sequencer for the RRAM array-access state counter: one WRITE/READ/FORM
// operation at a time, with a per-operation watchdog, response code and OK counter.
module rram_op_sequencer #(
    parameter int WRITE_TO = 40,
    parameter int READ_TO  = 40,
    parameter int FORM_TO  = 4200,
    parameter int TO_W     = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        err_clr,
    input  logic        write_count_flag,
    input  logic        cache_count_flag,
    input  logic        forming_count_flag,
    output logic        en,
    output logic        we,
    output logic        re,
    output logic        forming,
    output logic        done,
    output logic [1:0]  rsp_code,
    output logic        err,
    output logic [15:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_FORM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t          r_state;
    logic [TO_W-1:0] r_wd;
    logic            w_flag;
    logic [TO_W-1:0] w_limit;

    // Completion flag and last legal watchdog value for the operation in progress.
    always_comb begin
        w_flag  = 1'b0;
        w_limit = {TO_W{1'b0}};
        case (r_state)
            S_WRITE: begin
                w_flag  = write_count_flag;
                w_limit = TO_W'(WRITE_TO - 1);
            end
            S_READ: begin
                w_flag  = cache_count_flag;
                w_limit = TO_W'(READ_TO - 1);
            end
            S_FORM: begin
                w_flag  = forming_count_flag;
                w_limit = TO_W'(FORM_TO - 1);
            end
            default: begin
                w_flag  = 1'b0;
                w_limit = {TO_W{1'b0}};
            end
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wd      <= {TO_W{1'b0}};
            cmd_ready <= 1'b0;
            en        <= 1'b0;
            we        <= 1'b0;
            re        <= 1'b0;
            forming   <= 1'b0;
            done      <= 1'b0;
            rsp_code  <= 2'b00;
            err       <= 1'b0;
            op_count  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    en   <= 1'b1;
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        r_wd      <= {TO_W{1'b0}};
                        case (cmd_op)
                            2'b00: begin
                                r_state <= S_WRITE;
                                we      <= 1'b1;
                            end
                            2'b01: begin
                                r_state <= S_READ;
                                re      <= 1'b1;
                            end
                            2'b10: begin
                                r_state <= S_FORM;
                                forming <= 1'b1;
                            end
                            default: begin
                                r_state  <= S_DONE;
                                done     <= 1'b1;
                                rsp_code <= 2'b10;
                            end
                        endcase
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_WRITE, S_READ, S_FORM: begin
                    // The flag is checked first so a flag on the last watchdog cycle still completes OK.
                    if (w_flag) begin
                        r_state  <= S_DONE;
                        we       <= 1'b0;
                        re       <= 1'b0;
                        forming  <= 1'b0;
                        done     <= 1'b1;
                        rsp_code <= 2'b00;
                        op_count <= op_count + 16'd1;
                    end else if (r_wd == w_limit) begin
                        r_state  <= S_ERR;
                        we       <= 1'b0;
                        re       <= 1'b0;
                        forming  <= 1'b0;
                        done     <= 1'b1;
                        rsp_code <= 2'b01;
                        err      <= 1'b1;
                        en       <= 1'b0;
                    end else begin
                        r_wd <= r_wd + TO_W'(1);
                    end
                end
                S_DONE: begin
                    // Strobe has been low for one full cycle by now, so the counter has cleared.
                    r_state   <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                S_ERR: begin
                    done <= 1'b0;
                    if (err_clr) begin
                        r_state   <= S_IDLE;
                        err       <= 1'b0;
                        en        <= 1'b1;
                        cmd_ready <= 1'b1;
                    end else begin
                        en        <= 1'b0;
                        cmd_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    we        <= 1'b0;
                    re        <= 1'b0;
                    forming   <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rram_op_sequencer.sv
// Randomized bench for rram_op_sequencer: each operation's outcome is predicted
// from the flag delay and the timeout limit, then checked cycle by cycle.
module tb_rram_op_sequencer;

    localparam int WRITE_TO = 40;
    localparam int READ_TO  = 40;
    localparam int FORM_TO  = 4200;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        err_clr;
    logic        write_count_flag;
    logic        cache_count_flag;
    logic        forming_count_flag;
    logic        en, we, re, forming, done, err;
    logic [1:0]  rsp_code;
    logic [15:0] op_count;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_count;
    int          form_cnt = 0;

    always #5 clk = ~clk;

    rram_op_sequencer #(
        .WRITE_TO(WRITE_TO), .READ_TO(READ_TO), .FORM_TO(FORM_TO), .TO_W(13)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .err_clr(err_clr),
        .write_count_flag(write_count_flag), .cache_count_flag(cache_count_flag),
        .forming_count_flag(forming_count_flag),
        .en(en), .we(we), .re(re), .forming(forming), .done(done),
        .rsp_code(rsp_code), .err(err), .op_count(op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic int limit_of(input logic [1:0] op);
        case (op)
            2'b00:   return WRITE_TO;
            2'b01:   return READ_TO;
            default: return FORM_TO;
        endcase
    endfunction

    task automatic set_flags(input logic [2:0] f);
        write_count_flag   = f[0];
        cache_count_flag   = f[1];
        forming_count_flag = f[2];
    endtask

    // k: edge (counted from strobe rise) at which the matching flag is sampled high.
    task automatic run_op(input logic [1:0] op, input int k, input int clr_wait);
        int         waited;
        int         lim;
        int         last;
        bit         ok;
        logic [2:0] exp_s;
        logic [2:0] fl;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            step;
            waited++;
        end
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        step;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        if (op == 2'b11) begin
            chk("ill_strobes", {forming, re, we}, 0);
            chk("ill_done", done, 1);
            chk("ill_rsp", rsp_code, 2'b10);
            chk("ill_ready", cmd_ready, 0);
            step;
            chk("ill_done_clr", {done, cmd_ready}, 2'b01);
            chk("ill_count", op_count, exp_count);
            return;
        end
        lim   = limit_of(op);
        ok    = (k <= lim);
        last  = ok ? k : lim;
        exp_s = 3'b001 << op;
        for (int c = 1; c <= last; c++) begin
            chk("strobe_on", {en, done, forming, re, we}, {2'b10, exp_s});
            fl = 3'($urandom) & ~exp_s;
            if (ok && c == k) fl = fl | exp_s;
            set_flags(fl);
            step;
        end
        set_flags(3'b000);
        chk("end_strobes", {forming, re, we}, 0);
        chk("end_done", done, 1);
        chk("end_rsp", rsp_code, ok ? 2'b00 : 2'b01);
        chk("end_err_en", {err, en}, ok ? 2'b01 : 2'b10);
        if (ok) begin
            exp_count = exp_count + 16'd1;
            step;
            chk("ok_ready", {done, cmd_ready}, 2'b01);
            chk("ok_count", op_count, exp_count);
        end else begin
            step;
            chk("err_hold", {done, en, err, cmd_ready}, 4'b0010);
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom);
            for (int c = 0; c < clr_wait; c++) begin
                step;
                chk("err_ignore", {we, re, forming, cmd_ready, en, err}, 6'b000001);
            end
            err_clr = 1'b1;
            step;
            err_clr   = 1'b0;
            cmd_valid = 1'b0;
            chk("err_clear", {en, err, cmd_ready}, 3'b101);
            chk("err_count", op_count, exp_count);
        end
    endtask

    initial begin
        #(10 * 150000);
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [1:0] op;
        int         k;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        err_clr = 1'b0;
        set_flags(3'b000);
        exp_count = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {cmd_ready, en, we, re, forming, done, err}, 0);
        chk("rst_rsp", rsp_code, 2'b00);
        chk("rst_count", op_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step;
        chk("post_rst", {en, cmd_ready}, 2'b11);

        run_op(2'b00, 33, 0);
        run_op(2'b01, 32, 0);
        run_op(2'b10, 4096, 0);
        run_op(2'b00, 1000, 3);
        run_op(2'b11, 0, 0);

        // FORM interrupted by reset after 100 cycles
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        step;
        cmd_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            chk("form_pre_rst", {forming, re, we}, 3'b100);
            step;
        end
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_outs", {cmd_ready, en, we, re, forming, done, err}, 0);
        chk("mid_rst_count", op_count, 16'd0);
        exp_count = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        step;
        chk("post_mid_rst", {en, cmd_ready}, 2'b11);

        run_op(2'b01, 40, 0);
        run_op(2'b00, 41, 2);
        run_op(2'b01, 5, 0);

        for (int i = 0; i < 20; i++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'b10 && ($urandom % 3 != 0 || form_cnt >= 3)) op = 2'($urandom % 2);
            if (op == 2'b10) begin
                form_cnt++;
                case ($urandom % 4)
                    0:       k = 4096;
                    1:       k = FORM_TO;
                    2:       k = FORM_TO + 1;
                    default: k = $urandom_range(1, 20);
                endcase
            end else begin
                case ($urandom % 5)
                    0:       k = 32;
                    1:       k = limit_of(op);
                    2:       k = limit_of(op) + 1;
                    3:       k = $urandom_range(1, limit_of(op));
                    default: k = $urandom_range(1, 8);
                endcase
            end
            run_op(op, k, $urandom_range(0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
